// File: rtl/npu_sched_pkg.sv
// Shared types, instruction field positions and buffer address helpers for the
// conv NPU PE-array scheduler.
package npu_sched_pkg;

    typedef enum logic [1:0] {
        LOAD_IDLE = 2'd0,
        LOAD_A    = 2'd1,
        LOAD_B    = 2'd2,
        LOAD_C    = 2'd3
    } load_mode_e;

    typedef enum logic [1:0] {
        WB_0    = 2'd0,
        WB_1    = 2'd1,
        WB_2    = 2'd2,
        WB_IDLE = 2'd3
    } wb_mode_e;

    // Instruction field bit positions
    localparam int F_LOAD_LO = 0;
    localparam int F_LOAD_HI = 1;
    localparam int F_BCAST   = 2;
    localparam int F_RELU    = 3;
    localparam int F_WB_LO   = 4;
    localparam int F_WB_HI   = 5;
    localparam int F_REUSE   = 6;
    localparam int F_FLUSH   = 7;

    // Operand buffer base address for each load target: A, then B, then C.
    function automatic int buf_base(input load_mode_e mode, input int n, input int k);
        case (mode)
            LOAD_A:  return 0;
            LOAD_B:  return n * k;
            LOAD_C:  return 2 * n * k;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/npu_wrap_ctr.sv
// Wrapping up-counter: counts 0..MAX while enabled, synchronous clear has
// priority, wrap flags the enabled cycle in which the count returns to zero.
module npu_wrap_ctr #(
    parameter int MAX = 1,
    parameter int W   = (MAX < 1) ? 1 : $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] count,
    output logic         wrap
);

    assign wrap = en && (count == W'(MAX));

    // Count register: clear beats enable, wrap back to zero after MAX.
    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= wrap ? '0 : count + W'(1);
        end
    end

endmodule

// File: rtl/npu_conv_scheduler.sv
// PE-array scheduler: decodes instructions into operand-buffer writes, drives
// the PE array through K*K-tap windows under compute-credit backpressure and
// reports line completion.
module npu_conv_scheduler
    import npu_sched_pkg::*;
#(
    parameter int N               = 10,
    parameter int K_SIZE          = 3,
    parameter int LINE_COUNT      = 14,
    parameter int CREDIT_MAX      = 2 * K_SIZE * K_SIZE,
    parameter int W_IN            = 8,
    parameter int SEL_DEMUX_WIDTH = $clog2(2 * N * K_SIZE + K_SIZE),
    parameter int SEL_MUX_A_WIDTH = $clog2(K_SIZE * K_SIZE),
    parameter int SEL_MUX_B_WIDTH = $clog2(2 * K_SIZE * K_SIZE)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [W_IN-1:0]            instr,
    input  logic                       instr_valid,
    output logic                       instr_ready,
    output logic                       wen,
    output logic [SEL_DEMUX_WIDTH-1:0] pe_demux_sel,
    output logic [N-1:0]               pe_en,
    output logic [N-1:0]               pe_mode_sel,
    output logic [N-1:0]               pe_reg_reset,
    output logic [SEL_MUX_A_WIDTH-1:0] pe_mux_a_sel,
    output logic [SEL_MUX_B_WIDTH-1:0] pe_mux_b_sel,
    output logic [1:0]                 write_back_mode,
    output logic                       busy,
    output logic                       line_done
);

    localparam int KK    = K_SIZE * K_SIZE;
    localparam int PTR_W = $clog2(N * K_SIZE);
    localparam int PC_W  = (K_SIZE > 1) ? $clog2(K_SIZE) : 1;
    localparam int WIN_W = (LINE_COUNT > 1) ? $clog2(LINE_COUNT) : 1;
    localparam int CW    = $clog2(CREDIT_MAX + 1);
    localparam int MW    = (SEL_MUX_B_WIDTH + 2 > 8) ? SEL_MUX_B_WIDTH + 2 : 8;

    if (W_IN < 8) begin : g_w_in_check
        $error("npu_conv_scheduler: W_IN must be at least 8");
    end

    // ---------------- decode ----------------
    load_mode_e load_mode;
    wb_mode_e   wb_field;
    logic       acc, flush, op, load_c;

    assign load_mode = load_mode_e'(instr[F_LOAD_HI:F_LOAD_LO]);
    assign wb_field  = wb_mode_e'(instr[F_WB_HI:F_WB_LO]);
    assign acc       = instr_valid & instr_ready;
    assign flush     = acc & instr[F_FLUSH];
    assign op        = acc & ~instr[F_FLUSH];
    assign load_c    = op && (load_mode == LOAD_C);
    assign wen       = op && (load_mode != LOAD_IDLE);

    // ---------------- load pointers ----------------
    logic [PTR_W-1:0] ptr_a, ptr_b;
    logic [PC_W-1:0]  ptr_c;
    logic             ptr_a_wrap, ptr_b_wrap, ptr_c_wrap;

    npu_wrap_ctr #(.MAX(N * K_SIZE - 1), .W(PTR_W)) u_ptr_a (
        .clk(clk), .rst_n(rst_n), .en(op && (load_mode == LOAD_A)), .clr(flush),
        .count(ptr_a), .wrap(ptr_a_wrap));
    npu_wrap_ctr #(.MAX(N * K_SIZE - 1), .W(PTR_W)) u_ptr_b (
        .clk(clk), .rst_n(rst_n), .en(op && (load_mode == LOAD_B)), .clr(flush),
        .count(ptr_b), .wrap(ptr_b_wrap));
    npu_wrap_ctr #(.MAX(K_SIZE - 1), .W(PC_W)) u_ptr_c (
        .clk(clk), .rst_n(rst_n), .en(load_c), .clr(flush),
        .count(ptr_c), .wrap(ptr_c_wrap));

    // Buffer write address: region base plus the selected pointer, zero when idle.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        int ptr_sel;
        ptr_sel      = 0;
        pe_demux_sel = '0;
        case (load_mode)
            LOAD_A:  ptr_sel = int'(ptr_a);
            LOAD_B:  ptr_sel = int'(ptr_b);
            LOAD_C:  ptr_sel = int'(ptr_c);
            default: ptr_sel = 0;
        endcase
        if (wen) begin
            pe_demux_sel = SEL_DEMUX_WIDTH'(buf_base(load_mode, N, K_SIZE) + ptr_sel);
        end
    end

    // ---------------- compute credit ----------------
    logic [CW-1:0] credit, credit_add;

    assign busy        = (credit != '0);
    assign instr_ready = (credit <= CW'(CREDIT_MAX - KK));
    assign credit_add  = load_c ? (instr[F_REUSE] ? CW'(KK) : CW'(K_SIZE)) : '0;

    // Credit: one unit consumed per busy cycle, refilled by accepted LOAD_C.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit <= '0;
        end else if (flush) begin
            credit <= '0;
        end else begin
            credit <= credit - CW'(busy) + credit_add;
        end
    end

    // ---------------- mode and write-back registers ----------------
    logic relu_q, bcast_q;

    // ReLU / broadcast latch on accepted LOAD_C; write-back mode latch unless "keep".
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            relu_q          <= 1'b0;
            bcast_q         <= 1'b0;
            write_back_mode <= WB_IDLE;
        end else if (flush) begin
            relu_q          <= 1'b0;
            bcast_q         <= 1'b0;
            write_back_mode <= WB_IDLE;
        end else begin
            if (load_c) begin
                relu_q  <= instr[F_RELU];
                bcast_q <= instr[F_BCAST];
            end
            if (op && (wb_field != WB_IDLE)) begin
                write_back_mode <= wb_field;
            end
        end
    end

    // ---------------- window sequencing ----------------
    logic [SEL_MUX_A_WIDTH-1:0] img_ptr;
    logic [WIN_W-1:0]           win_cnt;
    logic [PC_W-1:0]            block_head;
    logic                       img_wrap, win_wrap, new_win, line_done_q;

    npu_wrap_ctr #(.MAX(KK - 1), .W(SEL_MUX_A_WIDTH)) u_img_ptr (
        .clk(clk), .rst_n(rst_n), .en(busy), .clr(flush),
        .count(img_ptr), .wrap(img_wrap));
    npu_wrap_ctr #(.MAX(LINE_COUNT - 1), .W(WIN_W)) u_win_cnt (
        .clk(clk), .rst_n(rst_n), .en(img_wrap), .clr(flush),
        .count(win_cnt), .wrap(win_wrap));

    // Block head advances per window, restarts at each line; window/line pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            block_head  <= '0;
            new_win     <= 1'b0;
            line_done_q <= 1'b0;
        end else if (flush) begin
            block_head  <= '0;
            new_win     <= 1'b0;
            line_done_q <= 1'b0;
        end else begin
            new_win     <= img_wrap;
            line_done_q <= win_wrap;
            if (win_wrap) begin
                block_head <= '0;
            end else if (img_wrap) begin
                block_head <= (block_head == PC_W'(K_SIZE - 1)) ? '0 : block_head + PC_W'(1);
            end
        end
    end

    // Weight tap: image tap rotated by the block head, offset into the broadcast bank.
    always_comb begin
        logic [MW-1:0] tap_sum, tap_mod;
        tap_sum      = MW'(img_ptr) + MW'(block_head) * MW'(K_SIZE);
        tap_mod      = tap_sum % MW'(KK);
        pe_mux_b_sel = SEL_MUX_B_WIDTH'(tap_mod + (bcast_q ? MW'(KK) : MW'(0)));
    end

    assign pe_en        = {N{busy}};
    assign pe_mode_sel  = {N{relu_q}};
    assign pe_reg_reset = {N{new_win}};
    assign pe_mux_a_sel = img_ptr;
    assign line_done    = line_done_q;

    logic unused_ok;
    assign unused_ok = ^{win_cnt, ptr_a_wrap, ptr_b_wrap, ptr_c_wrap};

    if (W_IN > 8) begin : g_upper_bits
        logic unused_upper;
        assign unused_upper = ^instr[W_IN-1:8];
    end

endmodule

// File: tb/tb_npu_conv_scheduler.sv
// Scoreboard bench for npu_conv_scheduler: stimulus pushes one expected output
// snapshot per cycle (-1 = don't care), a monitor pops and compares at negedge.
module tb_npu_conv_scheduler;

    localparam int N = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [7:0]  instr = 8'h00;
    logic        instr_valid = 1'b0;
    logic        instr_ready, wen, busy, line_done;
    logic [5:0]  pe_demux_sel;
    logic [N-1:0] pe_en, pe_mode_sel, pe_reg_reset;
    logic [3:0]  pe_mux_a_sel;
    logic [4:0]  pe_mux_b_sel;
    logic [1:0]  write_back_mode;

    int checks = 0;
    int failures = 0;

    typedef struct {
        string tag;
        int wen, demux, en, mode, rr, mux_a, mux_b, wbm, busy, ld, rdy;
    } exp_t;

    exp_t sb_q[$];

    npu_conv_scheduler dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .wen(wen), .pe_demux_sel(pe_demux_sel),
        .pe_en(pe_en), .pe_mode_sel(pe_mode_sel), .pe_reg_reset(pe_reg_reset),
        .pe_mux_a_sel(pe_mux_a_sel), .pe_mux_b_sel(pe_mux_b_sel),
        .write_back_mode(write_back_mode), .busy(busy), .line_done(line_done));

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic exp_t blank(input string tag);
        exp_t e;
        e.tag = tag;
        e.wen = -1; e.demux = -1; e.en = -1; e.mode = -1; e.rr = -1; e.mux_a = -1;
        e.mux_b = -1; e.wbm = -1; e.busy = -1; e.ld = -1; e.rdy = -1;
        return e;
    endfunction

    function automatic exp_t reset_exp(input string tag);
        exp_t e;
        e = blank(tag);
        e.wen = 0; e.demux = 0; e.en = 0; e.mode = 0; e.rr = 0; e.mux_a = 0;
        e.mux_b = 0; e.wbm = 3; e.busy = 0; e.ld = 0; e.rdy = 1;
        return e;
    endfunction

    // replicated vector -> 1 / 0, or 2 if not uniform
    function automatic int rep(input logic [N-1:0] v);
        if (v == {N{1'b1}}) return 1;
        if (v == {N{1'b0}}) return 0;
        return 2;
    endfunction

    task automatic check(input string tag, input string field, input int expv, input int act);
        if (expv < 0) return;
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s.%s actual=%0d expected=%0d @%0t", tag, field, act, expv, $time);
        end
    endtask

    task automatic compare(input exp_t e);
        check(e.tag, "wen",          e.wen,   int'(wen));
        check(e.tag, "pe_demux_sel", e.demux, int'(pe_demux_sel));
        check(e.tag, "pe_en",        e.en,    rep(pe_en));
        check(e.tag, "pe_mode_sel",  e.mode,  rep(pe_mode_sel));
        check(e.tag, "pe_reg_reset", e.rr,    rep(pe_reg_reset));
        check(e.tag, "pe_mux_a_sel", e.mux_a, int'(pe_mux_a_sel));
        check(e.tag, "pe_mux_b_sel", e.mux_b, int'(pe_mux_b_sel));
        check(e.tag, "wb_mode",      e.wbm,   int'(write_back_mode));
        check(e.tag, "busy",         e.busy,  int'(busy));
        check(e.tag, "line_done",    e.ld,    int'(line_done));
        check(e.tag, "instr_ready",  e.rdy,   int'(instr_ready));
    endtask

    // Drive one cycle of stimulus and queue what the monitor should see this cycle.
    task automatic step(input logic [7:0] ins, input logic v, input exp_t e);
        @(posedge clk);
        #1;
        instr       = ins;
        instr_valid = v;
        sb_q.push_back(e);
    endtask

    // Monitor: compares the oldest expectation at the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                compare(e);
            end
        end
    end

    initial begin
        exp_t e;
        bit   acc_t;
        int   img, bh;

        // ---- reset ----
        #1 rst_n = 1'b0;
        #2 compare(reset_exp("reset"));
        #9 rst_n = 1'b1;

        // ---- 31 LOAD_A then two LOAD_B ----
        for (int i = 0; i < 31; i++) begin
            e = blank("load_a"); e.wen = 1; e.demux = i % 30; e.en = 0; e.busy = 0;
            e.rdy = 1; e.wbm = 3;
            step(8'h31, 1'b1, e);
        end
        for (int i = 0; i < 2; i++) begin
            e = blank("load_b"); e.wen = 1; e.demux = 30 + i; e.en = 0;
            step(8'h32, 1'b1, e);
        end

        // ---- single LOAD_C reuse relu window ----
        e = blank("lc_accept"); e.wen = 1; e.demux = 60; e.busy = 0; e.rdy = 1;
        step(8'h7B, 1'b1, e);
        for (int i = 0; i < 9; i++) begin
            e = blank("lc_window"); e.wen = 0; e.demux = 0; e.busy = 1; e.en = 1;
            e.mux_a = i; e.mux_b = i; e.mode = 1; e.rr = 0;
            step(8'h00, 1'b0, e);
        end
        e = blank("lc_after"); e.busy = 0; e.en = 0; e.rr = 1; e.mux_a = 0; e.mux_b = 3;
        e.mode = 1;
        step(8'h00, 1'b0, e);
        e = blank("lc_after2"); e.busy = 0; e.rr = 0;
        step(8'h00, 1'b0, e);
        e = blank("flush1"); e.wen = 0; e.demux = 0;
        step(8'h80, 1'b1, e);

        // ---- credit backpressure ----
        e = blank("bp_d0"); e.wen = 1; e.demux = 60; e.busy = 0; e.rdy = 1; e.mux_a = 0;
        step(8'h7B, 1'b1, e);
        e = blank("bp_d1"); e.busy = 1; e.rdy = 1; e.wen = 1; e.demux = 61; e.mode = 1;
        e.mux_a = 0;
        step(8'h33, 1'b1, e);
        e = blank("bp_d2"); e.busy = 1; e.rdy = 0; e.wen = 0; e.demux = 0; e.mode = 0;
        e.mux_a = 1;
        step(8'h33, 1'b1, e);
        e = blank("bp_d3"); e.busy = 1; e.rdy = 0; e.wen = 0; e.mux_a = 2;
        step(8'h33, 1'b1, e);
        for (int t = 4; t <= 14; t++) begin
            e = blank("bp_drain"); e.busy = (t <= 12); e.rdy = 1;
            e.mux_a = (t >= 13) ? 3 : (t - 1) % 9; e.rr = (t == 10);
            step(8'h00, 1'b0, e);
        end
        e = blank("flush2"); e.wen = 0;
        step(8'h80, 1'b1, e);

        // ---- full line of broadcast reuse windows ----
        for (int t = 0; t <= 128; t++) begin
            acc_t = (t == 0) || (t >= 9 && t <= 117 && (t % 9) == 0);
            img   = (t == 0 || t > 127) ? 0 : (t - 1) % 9;
            bh    = (t >= 1 && t <= 126) ? ((t - 1) / 9) % 3 : 0;
            e = blank("bcast_line");
            e.busy  = (t >= 1 && t <= 126);
            e.en    = e.busy;
            e.mux_a = img;
            e.mux_b = (t == 0) ? 0 : ((img + bh * 3) % 9) + 9;
            e.rr    = (t >= 10 && t <= 127 && ((t - 1) % 9) == 0);
            e.ld    = (t == 127);
            e.wen   = acc_t;
            e.rdy   = 1;
            step(acc_t ? 8'h77 : 8'h00, acc_t, e);
        end

        // ---- write-back mode latch / keep ----
        e = blank("wb_set"); e.wen = 1; e.demux = 0; e.wbm = 3;
        step(8'h21, 1'b1, e);
        e = blank("wb_keep"); e.wen = 0; e.wbm = 2;
        step(8'h30, 1'b1, e);
        e = blank("wb_hold"); e.wbm = 2;
        step(8'h00, 1'b0, e);

        // ---- flush mid-compute at credit 5 ----
        e = blank("fl_accept"); e.wen = 1; e.demux = 62;
        step(8'h7F, 1'b1, e);
        for (int i = 0; i < 4; i++) begin
            e = blank("fl_busy"); e.busy = 1; e.mux_a = i;
            step(8'h00, 1'b0, e);
        end
        e = blank("fl_cmd"); e.busy = 1; e.wen = 0; e.demux = 0; e.mux_a = 4; e.mux_b = 13;
        e.mode = 1; e.wbm = 2;
        step(8'h80, 1'b1, e);
        e = blank("fl_after"); e.busy = 0; e.en = 0; e.mux_a = 0; e.mux_b = 0; e.mode = 0;
        e.rr = 0; e.wbm = 3; e.rdy = 1; e.wen = 1; e.demux = 0; e.ld = 0;
        step(8'h31, 1'b1, e);
        e = blank("fl_ptr_b"); e.wen = 1; e.demux = 30; e.busy = 0;
        step(8'h32, 1'b1, e);

        // ---- async reset on the wrap cycle ----
        e = blank("ar_accept"); e.wen = 1; e.demux = 60;
        step(8'h5B, 1'b1, e);
        for (int i = 0; i < 8; i++) begin
            e = blank("ar_busy"); e.busy = 1; e.wbm = 1; e.mux_a = i;
            step(8'h00, 1'b0, e);
        end
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        instr       = 8'h00;
        e = blank("ar_pre"); e.busy = 1; e.mux_a = 8; e.wbm = 1;
        compare(e);
        #1 rst_n = 1'b0;
        #1 compare(reset_exp("ar_reset"));
        @(negedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            e = reset_exp("ar_post");
            step(8'h00, 1'b0, e);
        end

        // ---- drain scoreboard with a bounded wait ----
        for (int i = 0; i < 5 && sb_q.size() > 0; i++) @(negedge clk);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL drain actual=%0d required=0 pending", sb_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/npu_conv_scheduler.md
Name: npu_conv_scheduler

Overview:
Parametrised next-generation PE-array scheduler for the conv NPU. It decodes 8-bit instructions into buffer-write, PE-control and write-back signals. New over the prior scheduler: a valid/ready instruction handshake with compute-credit backpressure, latched mode bits, a flush command, and line-completion and busy status. It sits between the instruction fetch/FIFO and the PE array plus operand buffers.

Parameters:
N, 10, number of PEs in the array
K_SIZE, 3, kernel edge; window = K_SIZE*K_SIZE taps
LINE_COUNT, 14, windows per output line
CREDIT_MAX, 2*K_SIZE*K_SIZE, max outstanding compute cycles
W_IN, 8, instruction width; must be >= 8, elaboration error otherwise
SEL_DEMUX_WIDTH, $clog2(2*N*K_SIZE+K_SIZE), buffer write address width
SEL_MUX_A_WIDTH, $clog2(K_SIZE*K_SIZE), image tap select width
SEL_MUX_B_WIDTH, $clog2(2*K_SIZE*K_SIZE), weight tap select width

Ports:
clk  in  1  work clock
rst_n  in  1  asynchronous active-low reset
instr  in  W_IN  instruction payload
instr_valid  in  1  payload valid
instr_ready  out  1  scheduler can accept
wen  out  1  operand buffer write enable
pe_demux_sel  out  SEL_DEMUX_WIDTH  buffer write address
pe_en  out  N  PE enable, replicated
pe_mode_sel  out  N  ReLU mode, replicated
pe_reg_reset  out  N  accumulator clear, replicated
pe_mux_a_sel  out  SEL_MUX_A_WIDTH  image tap index
pe_mux_b_sel  out  SEL_MUX_B_WIDTH  weight tap index
write_back_mode  out  2  write-back selector
busy  out  1  compute in progress
line_done  out  1  one-cycle pulse on line completion

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Accept rule: acc = instr_valid & instr_ready.
- Instruction fields:
  - [1:0] load_mode: 0 none, 1 A, 2 B, 3 C
  - [2] broadcast
  - [3] relu
  - [5:4] wb; 3 = keep current
  - [6] reuse
  - [7] flush
- instr_ready = (credit <= CREDIT_MAX - K*K). It is independent of instr and instr_valid.
- Load path (combinational from acc and load_mode):
  - wen = 1 when acc and load_mode != 0.
  - pe_demux_sel = base + ptr. Bases: A = 0, B = N*K, C = 2*N*K.
  - The selected ptr advances on the next edge. ptr_a and ptr_b wrap at N*K-1; ptr_c wraps at K-1.
  - When not loading: wen = 0, pe_demux_sel = 0.
- Credit counter (width $clog2(CREDIT_MAX+1)):
  - credit_next = credit - busy + add. add = (reuse ? K*K : K) on acc with load_mode == 3, else 0.
  - busy = (credit != 0), registered-state derived.
  - Simultaneous decrement and add is legal.
  - Accepted load_mode == 3 also latches relu and broadcast into mode registers.
- Compute outputs:
  - pe_en = {N{busy}}.
  - pe_mode_sel = {N{relu_q}}.
  - pe_mux_a_sel = img_ptr.
  - pe_mux_b_sel = ((img_ptr + block_head*K) mod K*K) + (broadcast_q ? K*K : 0).
  - Compute mux index arithmetic at 8 bits minimum before truncating.
- Window sequencing (each busy cycle img_ptr increments, wrapping at K*K-1). On the wrap cycle:
  - Registered new_win = 1 next cycle, driving pe_reg_reset = {N{1}} for exactly one cycle.
  - win_cnt increments.
  - If win_cnt == LINE_COUNT-1: win_cnt <= 0, block_head <= 0, line_done pulses next cycle.
  - Otherwise block_head <= (block_head + 1) mod K.
- Idle: when not busy, img_ptr, block_head and win_cnt hold.
- write_back_mode: on acc with wb != 3, register wb. Otherwise hold.
- Flush: acc with flush = 1 overrides all other fields (wen = 0). Next cycle, all pointers, credit, img_ptr, block_head, win_cnt, new_win and mode regs are 0. write_back_mode resets to 3.
- Reset values: all counters 0, write_back_mode = 3, every output 0 except write_back_mode = 3 and instr_ready = 1. Reset mid-compute aborts immediately; no pending pulses survive.

Decomposition:
- Package npu_sched_pkg holds:
  - load_mode_e (LOAD_IDLE/A/B/C)
  - wb_mode_e (WB_0/1/2/IDLE)
  - instruction field bit-position localparams
  - helper function for buffer base offsets
- Sub-module npu_wrap_ctr: parametrised MAX, enable, sync clear, wrap flag. Instantiated for ptr_a, ptr_b, ptr_c, img_ptr and win_cnt.

Test Plan:
- Reset, then 31 accepted LOAD_A instrs -> wen = 1 each cycle; pe_demux_sel = 0..29, then 0; pe_en = 0 throughout.
- LOAD_C with reuse = 1, relu = 1 -> busy for exactly 9 cycles; pe_mux_a_sel 0..8; pe_mode_sel all 1; pe_reg_reset pulses once, cycle after img_ptr = 8.
- Back-to-back LOAD_C reuse while credit = 9 -> instr_ready = 1. At credit = 10, instr_ready = 0 with instr_valid held, instr not accepted, no credit change.
- 14 consecutive reuse windows with broadcast = 1 -> block_head sequence 0,1,2,0,…; pe_mux_b_sel offset +9; line_done single pulse after 14th window; block_head = 0.
- instr wb = 2 then wb = 3 -> write_back_mode = 2 and stays 2.
- Flush mid-compute (credit = 5) -> next cycle busy = 0, all selects 0, write_back_mode = 3. Async rst_n low mid-window -> outputs at reset values without waiting for clk.
